ps2_rx_fifo: RTL

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised ps2_clk falling-edge sampling, 11-bit frame
// check (start/8 data/odd parity/stop) and a scan-code FIFO with sticky error flags.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  nextdata_n,
  input  logic                  clr_err,
  output logic [7:0]            data,
  output logic                  ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DEPTH_LOG2:0] FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TW-1:0]       TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                  r_meta, r_s1, r_s2;
  logic [3:0]            r_cnt;
  logic [8:0]            r_shift;
  logic [TW-1:0]         r_to;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_ovf, r_perr, r_ferr;

  logic w_sample, w_frame_done, w_stop_bad, w_par_bad, w_frame_ok, w_timeout;
  logic w_pop, w_push, w_ovf;

  // Reset to ones: ps2_clk idles high, so release never looks like a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_meta <= 1'b1;
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
    end else begin
      r_meta <= ps2_clk;
      r_s1   <= r_meta;
      r_s2   <= r_s1;
    end
  end

  assign w_sample     = r_s2 & ~r_s1;
  assign w_frame_done = w_sample && (r_cnt == 4'd10);
  assign w_stop_bad   = w_frame_done & ~ps2_data;
  assign w_par_bad    = w_frame_done & ps2_data & ~(^r_shift);
  assign w_frame_ok   = w_frame_done & ps2_data & (^r_shift);
  assign w_timeout    = (r_cnt != 4'd0) && !w_sample && (r_to == TO_LAST);

  // Bits 1..9 shift in from the top, so after nine shifts r_shift = {parity, data}.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt   <= 4'd0;
      r_shift <= 9'd0;
      r_to    <= '0;
    end else if (w_sample) begin
      r_to <= '0;
      if (r_cnt == 4'd0) begin
        if (!ps2_data) r_cnt <= 4'd1;
      end else if (r_cnt == 4'd10) begin
        r_cnt <= 4'd0;
      end else begin
        r_cnt   <= r_cnt + 4'd1;
        r_shift <= {ps2_data, r_shift[8:1]};
      end
    end else if (r_cnt == 4'd0) begin
      r_to <= '0;
    end else if (w_timeout) begin
      r_cnt <= 4'd0;
      r_to  <= '0;
    end else begin
      r_to <= r_to + 1'b1;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_pop  = (r_level != '0) & ~nextdata_n;
  assign w_push = w_frame_ok & ((r_level != FULL) | w_pop);
  assign w_ovf  = w_frame_ok & ~w_push;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift[7:0];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A fresh error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= (r_ovf  & ~clr_err) | w_ovf;
      r_perr <= (r_perr & ~clr_err) | w_par_bad;
      r_ferr <= (r_ferr & ~clr_err) | w_stop_bad | w_timeout;
    end
  end

  assign data       = r_mem[r_rptr];
  assign ready      = (r_level != '0);
  assign level      = r_level;
  assign overflow   = r_ovf;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;

endmodule
